// File: rtl/instruction_loader_pkg.sv
// Debug-unit shared definitions: loader FSM encoding,
// halt instruction and packing geometry.
package instruction_loader_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [31:0] HALT_WORD = 32'hFC000000;
    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/instruction_loader_byte_packer.sv
// Packs UART bytes MSB first into 32-bit words.
// Ports: clk, rst_n, clear, shift, rx_data -> word, word_valid.
module instruction_loader_byte_packer
    import instruction_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  rx_data,
    output logic [31:0] word,
    output logic        word_valid
);

    // Only the three oldest bytes need storing; the fourth
    // is taken straight from rx_data when the word completes.
    logic [23:0]      shreg;
    logic [CNT_W-1:0] byte_cnt;

    assign word       = {shreg, rx_data};
    assign word_valid = shift &&
                        (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (shift) begin
            shreg    <= {shreg[15:0], rx_data};
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Loads the program from the UART byte stream into
// instruction memory at word addresses 0,1,2...
// Ports: clk, rst_n, start, rx_data, rx_done ->
//   wr_en, wr_addr, wr_data, busy, load_done,
//   overflow, words_loaded.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int len_addr  = 32,
    parameter int len_data  = 32,
    parameter int ram_depth = 2048,
    parameter logic [len_data-1:0] halt_word = HALT_WORD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [7:0]          rx_data,
    input  logic                rx_done,
    output logic                wr_en,
    output logic [len_addr-1:0] wr_addr,
    output logic [len_data-1:0] wr_data,
    output logic                busy,
    output logic                load_done,
    output logic                overflow,
    output logic [len_addr-1:0] words_loaded
);

    localparam logic [len_addr-1:0] LAST = len_addr'(ram_depth - 1);

    logic [2:0]          state;
    logic [2:0]          nxt;
    logic [len_addr-1:0] addr;
    logic                start_ok;
    logic                shift;
    logic                is_halt;
    logic                at_last;
    logic [31:0]         word;
    logic                word_valid;

    assign is_halt  = (wr_data == halt_word);
    assign at_last  = (addr == LAST);
    assign start_ok = start && (state == S_IDLE ||
                                state == S_DONE ||
                                state == S_ERROR);

    // A byte landing in WRITE starts the next word, but only
    // when the load continues; otherwise it is dropped.
    assign shift = rx_done &&
                   (state == S_RECV ||
                    (state == S_WRITE && !is_halt && !at_last));

    instruction_loader_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok),
        .shift      (shift),
        .rx_data    (rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR:
                if (start) nxt = S_RECV;
            S_RECV:
                if (word_valid) nxt = S_WRITE;
            S_WRITE:
                if (is_halt)      nxt = S_DONE;
                else if (at_last) nxt = S_ERROR;
                else              nxt = S_RECV;
            default:
                nxt = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            addr         <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            busy         <= 1'b0;
            load_done    <= 1'b0;
            overflow     <= 1'b0;
            words_loaded <= '0;
        end else begin
            state     <= nxt;
            wr_en     <= (nxt == S_WRITE);
            busy      <= (nxt == S_RECV) || (nxt == S_WRITE);
            load_done <= (nxt == S_DONE);
            overflow  <= (nxt == S_ERROR);
            if (start_ok) begin
                addr         <= '0;
                words_loaded <= '0;
            end
            if (state == S_RECV && word_valid) begin
                wr_data <= word;
                wr_addr <= addr;
            end
            if (state == S_WRITE) begin
                words_loaded <= words_loaded + 1'b1;
                if (nxt == S_RECV) addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader (ram_depth=4)
// with a write scoreboard.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        load_done;
    logic        overflow;
    logic [31:0] words_loaded;

    int ntot = 0;
    int npass = 0;
    int nfail = 0;
    int nwr = 0;
    logic [63:0] sbq[$];
    logic [31:0] exp_addr = 0;

    instruction_loader #(
        .len_addr  (32),
        .len_data  (32),
        .ram_depth (4),
        .halt_word (32'hFC000000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .load_done    (load_done),
        .overflow     (overflow),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        logic [63:0] e;
        if (rst_n && wr_en) begin
            nwr++;
            check("wr_queued", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("wr_addr", wr_addr, e[63:32]);
                check("wr_data", wr_data, e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        sbq.push_back({exp_addr, w});
        exp_addr++;
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(load_done), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_words"}, words_loaded, 32'd0);
        check({tag, "_addr"}, wr_addr, 32'd0);
        check({tag, "_data"}, wr_data, 32'd0);
    endtask

    initial begin
        tick();
        tick();
        check_zero("rst");
        #2 rst_n = 1'b1;
        tick();

        // bytes before start are ignored
        send_byte(8'h20); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h05);
        check("pre_start_nwr", 32'(nwr), 32'd0);
        check("pre_start_busy", 32'(busy), 32'd0);

        // three-word load ending in halt
        pulse_start();
        exp_addr = 0;
        check("load_busy", 32'(busy), 32'd1);
        send_word(32'h20010005);
        send_word(32'h20020007);
        send_word(32'hFC000000);
        tick();
        check("l3_done", 32'(load_done), 32'd1);
        check("l3_words", words_loaded, 32'd3);
        check("l3_busy", 32'(busy), 32'd0);
        check("l3_ovf", 32'(overflow), 32'd0);
        check("l3_nwr", 32'(nwr), 32'd3);
        check("l3_hold_addr", wr_addr, 32'd2);
        check("l3_hold_data", wr_data, 32'hFC000000);

        // restart from DONE with a clashing rx_done byte
        rx_data = 8'hEE;
        rx_done = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        rx_done = 1'b0;
        exp_addr = 0;
        check("rs_done_drop", 32'(load_done), 32'd0);
        check("rs_busy", 32'(busy), 32'd1);
        check("rs_words", words_loaded, 32'd0);
        tick();
        send_byte(8'h11);
        send_byte(8'h22);
        pulse_start();
        check("recv_start_busy", 32'(busy), 32'd1);
        sbq.push_back({32'd0, 32'h11223344});
        sbq.push_back({32'd1, 32'h55667788});
        exp_addr = 2;
        send_byte(8'h33);
        rx_data = 8'h44;
        rx_done = 1'b1;
        tick();
        check("write_wr_en", 32'(wr_en), 32'd1);
        rx_data = 8'h55;
        tick();
        rx_done = 1'b0;
        tick();
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h88);

        // fill to the last entry without halt
        send_word(32'h01020304);
        send_word(32'h05060708);
        tick();
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_done", 32'(load_done), 32'd0);
        check("ovf_busy", 32'(busy), 32'd0);
        check("ovf_words", words_loaded, 32'd4);
        check("ovf_nwr", 32'(nwr), 32'd7);
        send_byte(8'hA1); send_byte(8'hA2);
        send_byte(8'hA3); send_byte(8'hA4);
        check("ovf_no5th", 32'(nwr), 32'd7);
        check("ovf_hold", 32'(overflow), 32'd1);
        check("ovf_addr_max", wr_addr, 32'd3);

        // halt in the last entry from ERROR restart
        pulse_start();
        exp_addr = 0;
        send_word(32'h00000001);
        send_word(32'h00000002);
        send_word(32'h00000003);
        send_word(32'hFC000000);
        tick();
        check("hl_done", 32'(load_done), 32'd1);
        check("hl_ovf", 32'(overflow), 32'd0);
        check("hl_words", words_loaded, 32'd4);
        check("hl_nwr", 32'(nwr), 32'd11);

        // asynchronous reset mid-word
        pulse_start();
        exp_addr = 0;
        send_byte(8'h01);
        send_byte(8'h02);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero("arst");
        #2 rst_n = 1'b1;
        tick();
        check("arst_nwr", 32'(nwr), 32'd11);
        pulse_start();
        exp_addr = 0;
        send_word(32'hAABBCCDD);
        tick();
        check("arst_words", words_loaded, 32'd1);
        check("arst_busy", 32'(busy), 32'd1);
        check("arst_addr", wr_addr, 32'd0);
        check("arst_data", wr_data, 32'hAABBCCDD);
        check("final_nwr", 32'(nwr), 32'd12);
        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer side of the instruction memory. Receives the program as a byte stream from the UART receiver and packs each 4 bytes, MSB first, into a 32-bit instruction.
- Writes each instruction into instruction memory at consecutive word addresses starting at 0. The address is a word index, matching how the memory indexes its array.
- Stops when it writes the halt instruction or when memory is full.
- Sits in the debug unit, between the UART RX and the instruction memory write port. It runs before the MIPS pipeline is released.

Parameters:
- len_addr, 32, width of the write address and of the word counter
- len_data, 32, instruction width; must be 32, since the block packs 4 bytes
- ram_depth, 2048, number of instruction memory entries
- halt_word, 32'hFC000000, instruction that ends the load; it is itself written to memory

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- start  in  1  one-cycle pulse that begins a load
- rx_data  in  8  byte from the UART receiver
- rx_done  in  1  one-cycle pulse; rx_data is valid in that cycle
- wr_en  out  1  memory write strobe, one cycle per word
- wr_addr  out  len_addr  word address of the write
- wr_data  out  len_data  instruction being written
- busy  out  1  high in RECV and WRITE
- load_done  out  1  high in DONE
- overflow  out  1  high in ERROR
- words_loaded  out  len_addr  words written in the current load

Behaviour:
- Reset is asynchronous and active low. While rst_n=0:
  - state=IDLE
  - all outputs 0
  - internal shift register, byte counter and address are 0
- Reset in the middle of a load abandons it; no further writes occur.
- All outputs are registered.
- IDLE:
  - start=1 moves to RECV next cycle and clears addr, byte_cnt, words_loaded.
  - rx_done is ignored.
- RECV:
  - On each rx_done: shreg <= {shreg[23:0], rx_data}; byte_cnt <= byte_cnt+1 (2-bit, wraps).
  - When rx_done arrives with byte_cnt=3:
    - wr_data <= {shreg[23:0], rx_data} and wr_addr <= addr on the same edge.
    - Next state WRITE.
- WRITE (exactly one cycle):
  - wr_en=1.
  - words_loaded increments on this edge.
  - Next state:
    - if wr_data==halt_word, go to DONE;
    - else if addr==ram_depth-1, go to ERROR;
    - else addr <= addr+1 and go to RECV.
  - An rx_done arriving in WRITE is accepted as byte 0 of the next word; no byte is lost.
  - If the state then goes to DONE or ERROR, that byte is discarded.
- Latency: wr_en is asserted in the cycle after the rx_done that carried the 4th byte.
- DONE: load_done=1 is held. start=1 restarts exactly as from IDLE (load_done drops next cycle). rx_done is ignored.
- ERROR: overflow=1 is held. start restarts as from DONE. rx_done is ignored.
- start in RECV or WRITE is ignored; there is no mid-load restart.
- Simultaneous start and rx_done in IDLE/DONE/ERROR: start is taken and the byte is discarded.
- The halt word written at address ram_depth-1 goes to DONE, not ERROR.
- wr_en is never asserted outside WRITE. wr_addr never exceeds ram_depth-1.
- wr_data and wr_addr hold their last value after the write.

Decomposition:
- Shared package (debug-unit package):
  - state encoding IDLE/RECV/WRITE/DONE/ERROR (3 bits)
  - HALT_WORD constant
  - BYTES_PER_WORD=4
- One natural sub-module, byte_packer: shift register plus byte counter, producing word and word_valid. The FSM stays in instruction_loader.

Test Plan:
- Three-word load: start, then bytes 20 01 00 05, 20 02 00 07, FC 00 00 00 → writes:
  - addr0=0x20010005
  - addr1=0x20020007
  - addr2=0xFC000000

  Then load_done=1, words_loaded=3, busy=0, and exactly 3 wr_en pulses.
- Byte arriving during WRITE: rx_done in the WRITE cycle → that byte appears as the MSB of the next word.
- Overflow: ram_depth=4, send 4 non-halt words → 4 writes at addresses 0..3, then overflow=1 and no 5th write even when more bytes are sent.
- Halt at the last entry: ram_depth=4, 3 words then the halt word → load_done=1 and overflow=0.
- Reset mid-word: after 2 bytes of word 1, pulse rst_n low asynchronously, between clock edges → outputs 0 at once. A new start followed by 4 bytes writes address 0 with exactly those 4 bytes.
- Ignored inputs:
  - rx_done before start gives no write.
  - start during RECV leaves addr and byte_cnt unchanged.
  - start in DONE begins a new load at address 0.
